// File: rtl/prng_fifo_pkg.sv
// Shared types for the PRNG FIFO streamer: fill modes, controller states and
// the FIFO address-width helper.
package prng_fifo_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_STEP  = 2'd1,
        MODE_AUTO  = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AUTO  = 2'd1,
        BURST = 2'd2
    } state_e;

    function automatic int fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/galois_lfsr_step.sv
// Galois LFSR that advances STEPS steps per enabled cycle and emits the
// shifted-out bits as one word (first shifted-out bit in word bit 0).
module galois_lfsr_step #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'hB8,
    parameter int               SEED  = 1,
    parameter int               STEPS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [STEPS-1:0] word
);

    // An all-zero state would lock the register up, so zero seeds become 1.
    localparam logic [WIDTH-1:0] SAFE_SEED = (SEED == 0) ? WIDTH'(1) : WIDTH'(SEED);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        logic [WIDTH-1:0] s;
        logic             ob;
        s    = state_q;
        word = '0;
        for (int i = 0; i < STEPS; i++) begin
            ob      = s[0];
            word[i] = ob;
            s       = (s >> 1) ^ ({WIDTH{ob}} & POLY);
        end
        state_d = s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SAFE_SEED;
        end else if (load) begin
            state_q <= (load_value == '0) ? WIDTH'(1) : load_value;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/prng_fifo_streamer.sv
// PRNG word source: a multi-step Galois LFSR pushes into a first-word
// fall-through FIFO drained by a valid/ready stream; STEP/AUTO/BURST fill control.
module prng_fifo_streamer
    import prng_fifo_pkg::*;
#(
    parameter int                    LFSR_WIDTH = 8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 8'hB8,
    parameter int                    LFSR_SEED  = 1,
    parameter int                    OUT_BITS   = 4,
    parameter int                    FIFO_DEPTH = 16,
    parameter int                    AF_THRESH  = 12,
    parameter int                    BURST_W    = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [1:0]                      mode,
    input  logic                            start,
    input  logic                            stop,
    input  logic [BURST_W-1:0]              burst_len,
    input  logic                            reseed,
    input  logic [LFSR_WIDTH-1:0]           seed_in,
    input  logic                            clr_err,
    output logic [OUT_BITS-1:0]             out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            empty,
    output logic                            full,
    output logic                            almost_full,
    output logic                            busy,
    output logic                            drop_err,
    output logic                            stall_err,
    output state_e                          dbg_state
);

    localparam int AW = fifo_aw(FIFO_DEPTH);
    localparam int LW = AW + 1;

    // Stream handshake: a word transfers on every rising edge where
    // out_valid && out_ready; out_valid never depends on out_ready.

    state_e               state_q, state_d;
    logic [BURST_W-1:0]   cnt_q, cnt_d;
    logic [OUT_BITS-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level_q, level_d;
    logic                 empty_q, full_q, af_q, drop_q, stall_q;
    logic                 gen_req, step_req, push_ok, pop, lfsr_load;
    logic [OUT_BITS-1:0]  gen_word;

    assign lfsr_load = reseed && (state_q == IDLE);
    assign push_ok   = gen_req && !full_q;
    assign pop       = !empty_q && out_ready;
    assign level_d   = level_q + LW'(push_ok) - LW'(pop);

    galois_lfsr_step #(
        .WIDTH (LFSR_WIDTH),
        .POLY  (LFSR_POLY),
        .SEED  (LFSR_SEED),
        .STEPS (OUT_BITS)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .load       (lfsr_load),
        .load_value (seed_in),
        .enable     (push_ok),
        .word       (gen_word)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gen_req  = 1'b0;
        step_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (mode)
                        // A reseed in the same cycle takes the LFSR; the step is not issued.
                        MODE_STEP: begin
                            step_req = !lfsr_load;
                            gen_req  = !lfsr_load;
                        end
                        MODE_AUTO: state_d = AUTO;
                        MODE_BURST: begin
                            if (burst_len != '0) begin
                                state_d = BURST;
                                cnt_d   = burst_len;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            AUTO: begin
                if (stop) state_d = IDLE;
                else      gen_req = 1'b1;
            end
            BURST: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    gen_req = 1'b1;
                    if (!full_q) begin
                        cnt_d = cnt_q - BURST_W'(1);
                        if (cnt_q == BURST_W'(1)) state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            drop_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            level_q <= level_d;
            empty_q <= (level_d == '0);
            full_q  <= (level_d == LW'(FIFO_DEPTH));
            af_q    <= (level_d >= LW'(AF_THRESH));
            // A new error event in the clear cycle keeps the flag set.
            drop_q  <= (step_req && full_q) || (drop_q && !clr_err);
            stall_q <= (out_ready && empty_q) || (stall_q && !clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= gen_word;
    end

    assign out_data    = empty_q ? '0 : mem[rd_ptr];
    assign out_valid   = !empty_q;
    assign level       = level_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign busy        = (state_q != IDLE);
    assign drop_err    = drop_q;
    assign stall_err   = stall_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_prng_fifo_streamer.sv
// Bench for prng_fifo_streamer: directed scenarios then random traffic, all
// outputs compared every cycle against a queue-based behavioural model.
module tb_prng_fifo_streamer;
    import prng_fifo_pkg::*;

    localparam int DEPTH    = 16;
    localparam int AF       = 12;
    localparam int OUT_BITS = 4;
    localparam int POLY     = 'hB8;
    localparam int SEED     = 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [1:0]          mode = '0;
    logic                start = 1'b0, stop = 1'b0, reseed = 1'b0, clr_err = 1'b0;
    logic [7:0]          burst_len = '0;
    logic [7:0]          seed_in = '0;
    logic [OUT_BITS-1:0] out_data;
    logic                out_valid, out_ready = 1'b0;
    logic [4:0]          level;
    logic                empty, full, almost_full, busy, drop_err, stall_err;
    state_e              dbg_state;

    int tests = 0;
    int fails = 0;

    // Behavioural model: FIFO contents as a queue, controller as a small state id.
    logic [OUT_BITS-1:0] exp_q[$];
    int unsigned         m_lfsr = SEED;
    int                  m_st = 0;      // 0 idle, 1 auto, 2 burst
    int                  m_left = 0;
    bit                  m_drop = 0, m_stall = 0;

    prng_fifo_streamer dut (
        .clk(clk), .reset(reset), .mode(mode), .start(start), .stop(stop),
        .burst_len(burst_len), .reseed(reseed), .seed_in(seed_in), .clr_err(clr_err),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .empty(empty), .full(full), .almost_full(almost_full),
        .busy(busy), .drop_err(drop_err), .stall_err(stall_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic make_word(output logic [OUT_BITS-1:0] w);
        int unsigned b;
        w = '0;
        for (int k = 0; k < OUT_BITS; k++) begin
            b = m_lfsr % 2;
            if (b != 0) w[k] = 1'b1;
            m_lfsr = (m_lfsr / 2) ^ ((b != 0) ? POLY : 0);
        end
    endtask

    task automatic model_edge();
        bit was_full, was_valid, gen, push, pop;
        int nxt;
        logic [OUT_BITS-1:0] w;
        was_full  = (exp_q.size() == DEPTH);
        was_valid = (exp_q.size() != 0);
        gen = 0;
        nxt = m_st;
        if (reset) begin
            exp_q.delete();
            m_lfsr = SEED; m_st = 0; m_left = 0; m_drop = 0; m_stall = 0;
            return;
        end
        if (m_st == 0) begin
            if (reseed) m_lfsr = (seed_in == 0) ? 1 : int'(seed_in);
            if (start && mode == 2'd1 && !reseed) gen = 1;
            if (start && mode == 2'd2) nxt = 1;
            if (start && mode == 2'd3 && burst_len != 0) begin
                nxt = 2;
                m_left = burst_len;
            end
        end else if (stop) begin
            nxt = 0;
        end else begin
            gen = 1;
        end
        push = gen && !was_full;
        pop  = was_valid && out_ready;
        if (clr_err) begin m_drop = 0; m_stall = 0; end
        if (m_st == 0 && gen && was_full) m_drop = 1;
        if (out_ready && !was_valid) m_stall = 1;
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            make_word(w);
            exp_q.push_back(w);
            if (m_st == 2) begin
                m_left--;
                if (m_left == 0) nxt = 0;
            end
        end
        m_st = nxt;
    endtask

    task automatic check_all();
        check("level", level, exp_q.size());
        check("out_valid", out_valid, exp_q.size() != 0);
        check("empty", empty, exp_q.size() == 0);
        check("full", full, exp_q.size() == DEPTH);
        check("almost_full", almost_full, exp_q.size() >= AF);
        check("busy", busy, m_st != 0);
        check("dbg_state_active", dbg_state != IDLE, m_st != 0);
        check("drop_err", drop_err, m_drop);
        check("stall_err", stall_err, m_stall);
        if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
    endtask

    // One clock: model follows the edge, outputs checked 1 ns later, pulses cleared.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        start = 0; stop = 0; reseed = 0; clr_err = 0; reset = 0;
    endtask

    initial begin
        int n;
        // Reset state
        reset = 1; tick();
        reset = 1; tick();
        check("rst_out_data", out_data, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);

        // Two STEP words with the consumer stalled
        out_ready = 0;
        start = 1; mode = 2'd1; tick();
        start = 1; mode = 2'd1; tick();
        check("step_head", out_data, 4'h1);
        check("step_level", level, 2);
        out_ready = 1; tick();
        out_ready = 0;
        check("step_second", out_data, 4'h7);
        start = 1; mode = 2'd1; tick();
        check("step_third_level", level, 2);

        // AUTO fill to full, then stop
        reset = 1; tick();
        start = 1; mode = 2'd2; tick();
        n = 0;
        while (full !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("auto_fill_cycles", n, 16);
        check("auto_af", almost_full, 1);
        stop = 1; tick();
        check("auto_stop_busy", busy, 0);

        // STEP into a full FIFO drops the word and flags it
        start = 1; mode = 2'd1; tick();
        check("drop_set", drop_err, 1);
        check("drop_level", level, 16);
        clr_err = 1; tick();
        check("drop_clear", drop_err, 0);

        // Full FIFO: pop with AUTO active frees a slot, refilled next cycle
        start = 1; mode = 2'd2; tick();
        out_ready = 1; tick();
        check("full_pop_level", level, 15);
        out_ready = 0; tick();
        check("refill_level", level, 16);
        stop = 1; tick();

        // BURST of 5 with the consumer always ready
        reset = 1; tick();
        out_ready = 1;
        start = 1; mode = 2'd3; burst_len = 8'd5; tick();
        for (int i = 0; i < 10; i++) tick();
        check("burst_busy_end", busy, 0);
        check("burst_level_end", level, 0);
        out_ready = 0;

        // Reset in the middle of a burst restarts the sequence
        reset = 1; tick();
        start = 1; mode = 2'd3; burst_len = 8'd5; tick();
        tick(); tick();
        reset = 1; tick();
        check("midrst_busy", busy, 0);
        check("midrst_level", level, 0);
        check("midrst_empty", empty, 1);
        start = 1; mode = 2'd1; tick();
        check("midrst_first_word", out_data, 4'h1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            mode      = 2'($urandom_range(0, 3));
            stop      = ($urandom_range(0, 19) == 0);
            burst_len = 8'($urandom_range(0, 12));
            reseed    = ($urandom_range(0, 29) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            clr_err   = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
